// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with hazard stall/flush handling and address-error tagging.
// Optional performance counters are enabled with the IF_ID_PERF_EN macro.
module if_id_stage_reg #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      pc_if,
    input  logic [31:0]      instr_if,
    output logic [31:0]      pc_id,
    output logic [31:0]      pc_plus4_id,
    output logic [31:0]      instr_id,
    output logic             valid_id,
    output logic             adel_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic {
        BUBBLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] pc_plus4_reg;
    logic [31:0] instr_reg;
    logic        adel_reg;
    logic        misaligned;
    logic        load_en;

    assign misaligned = (pc_if[1:0] != 2'b00);
    assign load_en    = !flush && !stall;

    // Priority reset > flush > stall > load; a stall simply leaves every flop untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= BUBBLE;
            pc_reg       <= RESET_PC;
            pc_plus4_reg <= RESET_PC + 32'd4;
            instr_reg    <= NOP_WORD;
            adel_reg     <= 1'b0;
        end else if (flush) begin
            state_reg    <= BUBBLE;
            pc_reg       <= pc_if;
            pc_plus4_reg <= pc_if + 32'd4;
            instr_reg    <= NOP_WORD;
            adel_reg     <= 1'b0;
        end else if (!stall) begin
            state_reg    <= RUN;
            pc_reg       <= pc_if;
            pc_plus4_reg <= pc_if + 32'd4;
            // A faulting fetch keeps its PC for the exception handler but carries no instruction.
            instr_reg    <= misaligned ? NOP_WORD : instr_if;
            adel_reg     <= misaligned;
        end
    end

    assign pc_id       = pc_reg;
    assign pc_plus4_id = pc_plus4_reg;
    assign instr_id    = instr_reg;
    assign valid_id    = (state_reg == RUN);
    assign adel_id     = adel_reg;

`ifdef IF_ID_PERF_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];

    assign cnt_inc[0] = stall;
    assign cnt_inc[1] = flush;
    assign cnt_inc[2] = load_en;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi = gi + 1) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt  = cnt_reg[0];
    assign flush_cnt  = cnt_reg[1];
    assign retire_cnt = cnt_reg[2];
`else
    logic unused_load_en;
    assign unused_load_en = load_en;
    assign stall_cnt  = '0;
    assign flush_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Scoreboard testbench for if_id_stage_reg: directed vectors push expected entries,
// a monitor pops and compares one entry per clock edge.
module tb_if_id_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] pc_if = 32'h0;
    logic [31:0] instr_if = 32'h0;
    logic [31:0] pc_id;
    logic [31:0] pc_plus4_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        adel_id;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] retire_cnt;

    if_id_stage_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .pc_if      (pc_if),
        .instr_if   (instr_if),
        .pc_id      (pc_id),
        .pc_plus4_id(pc_plus4_id),
        .instr_id   (instr_id),
        .valid_id   (valid_id),
        .adel_id    (adel_id),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        adel;
        logic [31:0] scnt;
        logic [31:0] fcnt;
        logic [31:0] rcnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   txn = 0;

    // Expected counter values, tracked only when the counter bank is built in.
    logic [31:0] m_scnt = 0;
    logic [31:0] m_fcnt = 0;
    logic [31:0] m_rcnt = 0;

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Drive one cycle of stimulus and push the entry expected after the coming edge.
    task automatic step(input string name, input logic r, input logic s, input logic f,
                        input logic [31:0] pc, input logic [31:0] ins,
                        input logic [31:0] e_pc, input logic [31:0] e_pc4,
                        input logic [31:0] e_instr, input logic e_valid, input logic e_adel);
        exp_t e;
        @(negedge clk);
        reset = r; stall = s; flush = f; pc_if = pc; instr_if = ins;
`ifdef IF_ID_PERF_EN
        if (r) begin
            m_scnt = 0; m_fcnt = 0; m_rcnt = 0;
        end else begin
            if (s) m_scnt = m_scnt + 1;
            if (f) m_fcnt = m_fcnt + 1;
            if (!s && !f) m_rcnt = m_rcnt + 1;
        end
`endif
        e.name = name; e.pc = e_pc; e.pc4 = e_pc4; e.instr = e_instr;
        e.valid = e_valid; e.adel = e_adel;
        e.scnt = m_scnt; e.fcnt = m_fcnt; e.rcnt = m_rcnt;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            txn++;
            $display("txn %0d %s: pc_id=%h pc_plus4_id=%h instr_id=%h valid=%b adel=%b cnt=%0d/%0d/%0d",
                     txn, mon_e.name, pc_id, pc_plus4_id, instr_id, valid_id, adel_id,
                     stall_cnt, flush_cnt, retire_cnt);
            chk(mon_e.name, "pc_id", pc_id, mon_e.pc);
            chk(mon_e.name, "pc_plus4_id", pc_plus4_id, mon_e.pc4);
            chk(mon_e.name, "instr_id", instr_id, mon_e.instr);
            chk(mon_e.name, "valid_id", {31'b0, valid_id}, {31'b0, mon_e.valid});
            chk(mon_e.name, "adel_id", {31'b0, adel_id}, {31'b0, mon_e.adel});
            chk(mon_e.name, "stall_cnt", stall_cnt, mon_e.scnt);
            chk(mon_e.name, "flush_cnt", flush_cnt, mon_e.fcnt);
            chk(mon_e.name, "retire_cnt", retire_cnt, mon_e.rcnt);
        end
    end

    initial begin
        //    name          rst st fl pc_if         instr_if      pc_id         pc_plus4_id   instr_id      v     a
        step("reset0",      1, 0, 0, 32'h00400000, 32'h20080005, 32'h00000000, 32'h00000004, 32'h00000000, 1'b0, 1'b0);
        step("reset1",      1, 0, 0, 32'h00400000, 32'h20080005, 32'h00000000, 32'h00000004, 32'h00000000, 1'b0, 1'b0);
        step("load0",       0, 0, 0, 32'h00400000, 32'h20080005, 32'h00400000, 32'h00400004, 32'h20080005, 1'b1, 1'b0);
        step("load1",       0, 0, 0, 32'h00400004, 32'h2009000A, 32'h00400004, 32'h00400008, 32'h2009000A, 1'b1, 1'b0);
        step("stall0",      0, 1, 0, 32'h00400008, 32'h11111111, 32'h00400004, 32'h00400008, 32'h2009000A, 1'b1, 1'b0);
        step("stall1",      0, 1, 0, 32'h0040000C, 32'h22222222, 32'h00400004, 32'h00400008, 32'h2009000A, 1'b1, 1'b0);
        step("stall2",      0, 1, 0, 32'h00400010, 32'h33333333, 32'h00400004, 32'h00400008, 32'h2009000A, 1'b1, 1'b0);
        step("flush_stall", 0, 1, 1, 32'h00400008, 32'h44444444, 32'h00400008, 32'h0040000C, 32'h00000000, 1'b0, 1'b0);
        step("stall_bub",   0, 1, 0, 32'h0040000C, 32'h55555555, 32'h00400008, 32'h0040000C, 32'h00000000, 1'b0, 1'b0);
        step("load2",       0, 0, 0, 32'h00400008, 32'h8C0A0000, 32'h00400008, 32'h0040000C, 32'h8C0A0000, 1'b1, 1'b0);
        step("misalign",    0, 0, 0, 32'h00400002, 32'hDEADBEEF, 32'h00400002, 32'h00400006, 32'h00000000, 1'b1, 1'b1);
        step("wrap",        0, 0, 0, 32'hFFFFFFFC, 32'h03E00008, 32'hFFFFFFFC, 32'h00000000, 32'h03E00008, 1'b1, 1'b0);
        step("flush_only",  0, 0, 1, 32'h00400010, 32'h66666666, 32'h00400010, 32'h00400014, 32'h00000000, 1'b0, 1'b0);
        step("reset_mid",   1, 1, 1, 32'h00400014, 32'h77777777, 32'h00000000, 32'h00000004, 32'h00000000, 1'b0, 1'b0);
        step("load_after",  0, 0, 0, 32'h00400000, 32'h20080005, 32'h00400000, 32'h00400004, 32'h20080005, 1'b1, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
